handshake_transmitter: RTL and testbench

Serial transmitter for the handshake wire; the transmit-side counterpart of the handshake receiver. On a `send_start` pulse it latches an encoded header, then drives the syncword followed by the header onto one wire, MSB first, one bit per cycle. It raises `send_done` when the frame is complete and holds it until the next `send_start`. It sits between the network FSM, which supplies the header and the start pulse, and the GPIO output pin.

---
 rtl/handshake_transmitter.sv | 138 +++++++++++++
 tb/tb_handshake_transmitter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/handshake_transmitter.sv
// handshake_transmitter: serializes {SYNCWORD, encoded header} onto the
// handshake wire, MSB first, one bit per clock. Optional macro
// HS_TX_REPEAT_EN replaces the terminal DONE state with a GAP state that
// idles REPEAT_GAP cycles and then resends the latched frame.

package NetworkPkg;
  localparam int              SYNC_BITS     = 8;
  localparam logic [7:0]      SYNCWORD      = 8'hA5;
  localparam int              ENC_HEAD_BITS = 16;
endpackage

module handshake_transmitter #(
  parameter int                   SYNC_BITS     = NetworkPkg::SYNC_BITS,
  parameter logic [SYNC_BITS-1:0] SYNCWORD      = NetworkPkg::SYNCWORD,
  parameter int                   ENC_HEAD_BITS = NetworkPkg::ENC_HEAD_BITS,
  parameter int                   REPEAT_GAP    = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     send_start,
  input  logic                     game_active,
  input  logic [ENC_HEAD_BITS-1:0] data_in,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     send_done
);

  localparam int FRAME_BITS = SYNC_BITS + ENC_HEAD_BITS;

  // Reject parameter sets the 8-bit counter or the frame format cannot handle.
  if (SYNC_BITS < 1 || SYNC_BITS > 255 || ENC_HEAD_BITS < 1 ||
      ENC_HEAD_BITS > 255 || SYNCWORD == '0 ||
      REPEAT_GAP < 1 || REPEAT_GAP > 256) begin : g_bad_params
    $error("handshake_transmitter: illegal parameter set");
  end

`ifdef HS_TX_REPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP}  state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_DONE} state_t;
`endif

  state_t                state;
  logic [FRAME_BITS-1:0] frame;
  logic [7:0]            cnt;
  logic [FRAME_BITS-1:0] frame_next;

  // Advance the frame by one bit. In repeat mode the MSB wraps around so a
  // full pass leaves the frame intact for the next retransmission.
  always_comb begin
`ifdef HS_TX_REPEAT_EN
    frame_next = {frame[FRAME_BITS-2:0], frame[FRAME_BITS-1]};
`else
    frame_next = {frame[FRAME_BITS-2:0], 1'b0};
`endif
  end

  // Frame FSM. The outputs form a register stage that runs one cycle behind
  // the state: serial_out shows the bit the state held on the previous cycle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      // NOTE: every register here, frame included, takes the reset value so
      // serial_out can never show X after reset; sequential state uses <=.
      state      <= S_IDLE;
      frame      <= '0;
      cnt        <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      send_done  <= 1'b0;
    end else if (!game_active) begin
      // Losing the game wins over everything, including a pending start.
      state      <= S_IDLE;
      cnt        <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      send_done  <= 1'b0;
    end else if (send_start) begin
      // Start from idle/done, or abort and restart a frame in flight.
      state      <= S_SYNC;
      frame      <= {SYNCWORD, data_in};
      cnt        <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b1;
      send_done  <= 1'b0;
    end else begin
      serial_out <= 1'b0;
      busy       <= 1'b0;
      case (state)
        S_SYNC: begin
          serial_out <= frame[FRAME_BITS-1];
          busy       <= 1'b1;
          frame      <= frame_next;
          if (cnt == 8'(SYNC_BITS - 1)) begin
            state <= S_DATA;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DATA: begin
          serial_out <= frame[FRAME_BITS-1];
          busy       <= 1'b1;
          frame      <= frame_next;
          if (cnt == 8'(ENC_HEAD_BITS - 1)) begin
`ifdef HS_TX_REPEAT_EN
            state <= S_GAP;
`else
            state <= S_DONE;
`endif
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`ifdef HS_TX_REPEAT_EN
        S_GAP: begin
          busy      <= 1'b1;
          send_done <= 1'b1;
          if (cnt == 8'(REPEAT_GAP - 1)) begin
            state <= S_SYNC;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
`else
        S_DONE: begin
          send_done <= 1'b1;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_transmitter.sv
// tb_handshake_transmitter: table-driven frame vectors plus directed
// sequences for loopback, restart, game_active drop, repeat mode and
// asynchronous reset. Inputs change on the falling edge; outputs are
// compared on the falling edge after each rising edge.

module tb_handshake_transmitter;

  localparam int         SB  = 8;
  localparam int         EHB = 16;
  localparam int         RG  = 4;
  localparam logic [7:0] SW  = 8'hA5;
`ifdef HS_TX_REPEAT_EN
  localparam logic       REP = 1'b1;
`else
  localparam logic       REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        send_start = 1'b0;
  logic        game_active = 1'b0;
  logic [15:0] data_in = '0;
  logic        serial_out, busy, send_done;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  handshake_transmitter #(
    .SYNC_BITS(SB), .SYNCWORD(SW), .ENC_HEAD_BITS(EHB), .REPEAT_GAP(RG)
  ) dut (
    .clk(clk), .rst_l(rst_l), .send_start(send_start),
    .game_active(game_active), .data_in(data_in),
    .serial_out(serial_out), .busy(busy), .send_done(send_done)
  );

  typedef struct {
    logic        st;
    logic        ga;
    logic [15:0] d;
    logic        e_ser;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the rising edge, settle at the falling edge.
  task automatic step(input logic st, input logic ga, input logic [15:0] d);
    send_start  = st;
    game_active = ga;
    data_in     = d;
    @(posedge clk);
    @(negedge clk);
    send_start  = 1'b0;
  endtask

  task automatic check_outs(input string name, input logic s,
                            input logic b, input logic dn);
    check({name, " serial_out"}, serial_out, s);
    check({name, " busy"}, busy, b);
    check({name, " send_done"}, send_done, dn);
  endtask

  function automatic vec_t mk(input logic st, input logic [15:0] d,
                              input logic s, input logic b, input logic dn);
    vec_t v;
    v.st = st; v.ga = 1'b1; v.d = d;
    v.e_ser = s; v.e_busy = b; v.e_done = dn;
    return v;
  endfunction

  // Start edge, 24 serial bits, then two post-frame cycles.
  task automatic add_frame(input logic [15:0] d);
    logic [23:0] f;
    f = {SW, d};
    vecs.push_back(mk(1'b1, d, 1'b0, 1'b1, 1'b0));
    for (int k = 1; k <= 24; k++)
      vecs.push_back(mk(1'b0, d, f[24-k], 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, d, 1'b0, REP, 1'b1));
    vecs.push_back(mk(1'b0, d, 1'b0, REP, 1'b1));
  endtask

  initial begin
    logic [23:0] rx;

    // Reset state.
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst_l = 1'b1;

    // Table of full frames, back to back, with distinct headers.
    vecs.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0));
    add_frame(16'hBEEF);
    add_frame(16'h8001);
    add_frame(16'hFFFF);
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].ga, vecs[i].d);
      check($sformatf("vec%0d serial_out", i), serial_out, vecs[i].e_ser);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d send_done", i), send_done, vecs[i].e_done);
    end

    // Loopback: LSB-shift-in receiver model recovers syncword and header.
    step(1'b1, 1'b1, 16'hBEEF);
    rx = '0;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 1'b1, 16'h0000);
      rx = {rx[22:0], serial_out};
    end
    step(1'b0, 1'b1, 16'h0000);
    check("loopback data_out", rx[15:0], 16'hBEEF);
    check("loopback sync", rx[23:16], SW);
    check("loopback done", send_done, 1'b1);

    // Restart at N+10 with a new header.
    step(1'b1, 1'b1, 16'h1234);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 16'h5678);
    check("restart busy", busy, 1'b1);
    check("restart done", send_done, 1'b0);
    rx = '0;
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 1'b1, 16'h0000);
      rx = {rx[22:0], serial_out};
      check($sformatf("restart done low %0d", k), send_done, 1'b0);
    end
    check("restart frame", rx, {SW, 16'h5678});
    step(1'b0, 1'b1, 16'h0000);
    check("restart done at N+35", send_done, 1'b1);

    // game_active drop at N+12 while a 1 bit is on the wire.
    step(1'b1, 1'b1, 16'hBEEF);
    for (int k = 1; k <= 11; k++) step(1'b0, 1'b1, 16'hBEEF);
    check_outs("pre-drop N+11", 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'hBEEF);
    check_outs("drop N+12", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h1234);
    check_outs("start ignored", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h1234);
    check_outs("idle after drop 1", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h1234);
    check_outs("idle after drop 2", 1'b0, 1'b0, 1'b0);

`ifdef HS_TX_REPEAT_EN
    // Retransmission: frame, RG zero cycles, frame again.
    step(1'b1, 1'b1, 16'hBEEF);
    for (int p = 0; p < 2; p++) begin
      rx = '0;
      for (int k = 0; k < 24; k++) begin
        step(1'b0, 1'b1, 16'h0000);
        rx = {rx[22:0], serial_out};
        check($sformatf("repeat p%0d busy %0d", p, k), busy, 1'b1);
        check($sformatf("repeat p%0d done %0d", p, k), send_done, logic'(p));
      end
      check($sformatf("repeat frame p%0d", p), rx, {SW, 16'hBEEF});
      if (p == 0) begin
        for (int g = 0; g < RG; g++) begin
          step(1'b0, 1'b1, 16'h0000);
          check_outs($sformatf("gap %0d", g), 1'b0, 1'b1, 1'b1);
        end
      end
    end
    step(1'b0, 1'b0, 16'h0000);
    check_outs("repeat stop", 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset mid-frame at N+5.
    step(1'b1, 1'b1, 16'hBEEF);
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 16'hBEEF);
    check("pre-reset busy", busy, 1'b1);
    rst_l = 1'b0;
    #1;
    check_outs("async reset", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 16'hBEEF);
      check_outs($sformatf("post-reset idle %0d", k), 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
